// File: rtl/bcd_key_entry_pkg.sv
// Shared types and sizes for the BCD keypad entry block.
package bcd_key_entry_pkg;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    CONV  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int unsigned MAX_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned VALUE_W    = 16;
  localparam int unsigned BIN_W      = 14;

endpackage

// File: rtl/bcd_bin_step.sv
// One BCD-to-binary step: acc*10 + digit, built from shifts. Only compiled when
// BCD_KEY_ENTRY_BIN_EN is defined, because the top instantiates it only in that build.
`ifdef BCD_KEY_ENTRY_BIN_EN
module bcd_bin_step
  import bcd_key_entry_pkg::*;
(
  input  logic [BIN_W-1:0]   acc_i,
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [BIN_W-1:0]   acc_o
);

  assign acc_o = (acc_i << 3) + (acc_i << 1) + BIN_W'(digit_i);

endmodule
`endif

// File: rtl/bcd_key_entry.sv
// Keypad entry of up to four BCD digits, with optional serial BCD-to-binary conversion
// enabled by the macro BCD_KEY_ENTRY_BIN_EN.
module bcd_key_entry
  import bcd_key_entry_pkg::*;
(
  input  logic               clk,
  input  logic               CLR_N,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               digit_vld,
  input  logic               enter,
  input  logic               clear,
  output logic [VALUE_W-1:0] value,
  output logic [2:0]         ndigits,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef BCD_KEY_ENTRY_BIN_EN
  ,
  output logic [BIN_W-1:0]   bin
`endif
);

  state_e             state_q;
  logic [VALUE_W-1:0] value_q;
  logic [2:0]         ndigits_q;
  logic               busy_q, done_q, err_q, hold_entry_q;
  logic               digit_ok;

  assign digit_ok = (digit <= 4'd9);

`ifdef BCD_KEY_ENTRY_BIN_EN
  logic [BIN_W-1:0]   acc_q, bin_q, acc_next;
  logic [1:0]         cnt_q;
  logic [VALUE_W-1:0] value_shifted;

  // Walk the digits MSB first by shifting the current one into the top nibble.
  assign value_shifted = value_q << {cnt_q, 2'b00};

  bcd_bin_step u_step (
    .acc_i   (acc_q),
    .digit_i (value_shifted[VALUE_W-1 -: DIGIT_W]),
    .acc_o   (acc_next)
  );

  assign bin = bin_q;
`endif

  always_ff @(posedge clk or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q      <= ENTRY;
      value_q      <= '0;
      ndigits_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      hold_entry_q <= 1'b0;
`ifdef BCD_KEY_ENTRY_BIN_EN
      acc_q        <= '0;
      bin_q        <= '0;
      cnt_q        <= '0;
`endif
    end else begin
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      hold_entry_q <= 1'b0;
      if (clear) begin
        state_q   <= ENTRY;
        value_q   <= '0;
        ndigits_q <= '0;
        busy_q    <= 1'b0;
`ifdef BCD_KEY_ENTRY_BIN_EN
        bin_q     <= '0;
`endif
      end else begin
        done_q <= hold_entry_q;
        unique case (state_q)
          ENTRY: begin
            if (enter) begin
`ifdef BCD_KEY_ENTRY_BIN_EN
              state_q <= CONV;
              busy_q  <= 1'b1;
              acc_q   <= '0;
              cnt_q   <= '0;
`else
              state_q      <= HOLD;
              hold_entry_q <= 1'b1;
`endif
            end else if (digit_vld) begin
              if (digit_ok && (ndigits_q != 3'(MAX_DIGITS))) begin
                value_q   <= {value_q[VALUE_W-DIGIT_W-1:0], digit};
                ndigits_q <= ndigits_q + 3'd1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          CONV: begin
`ifdef BCD_KEY_ENTRY_BIN_EN
            acc_q <= acc_next;
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              bin_q        <= acc_next;
              state_q      <= HOLD;
              busy_q       <= 1'b0;
              hold_entry_q <= 1'b1;
            end
`else
            state_q <= ENTRY;
`endif
          end
          HOLD: begin
            if (!enter && digit_vld) begin
              if (digit_ok) begin
                value_q   <= {{(VALUE_W-DIGIT_W){1'b0}}, digit};
                ndigits_q <= 3'd1;
                state_q   <= ENTRY;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          default: state_q <= ENTRY;
        endcase
      end
    end
  end

  assign value   = value_q;
  assign ndigits = ndigits_q;
`ifdef BCD_KEY_ENTRY_BIN_EN
  assign busy    = busy_q;
`else
  assign busy    = 1'b0;
`endif
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_key_entry.sv
// Scoreboard bench for bcd_key_entry: a digit-list model predicts done/err pulses and busy.
`timescale 1ns/1ps
module tb_bcd_key_entry;

  logic        clk = 1'b0;
  logic        CLR_N = 1'b0;
  logic [3:0]  digit = '0;
  logic        digit_vld = 1'b0, enter = 1'b0, clear = 1'b0;
  logic [15:0] value;
  logic [2:0]  ndigits;
  logic        busy, done, err;
`ifdef BCD_KEY_ENTRY_BIN_EN
  logic [13:0] bin;
`endif

  bcd_key_entry dut (
    .clk       (clk),
    .CLR_N     (CLR_N),
    .digit     (digit),
    .digit_vld (digit_vld),
    .enter     (enter),
    .clear     (clear),
    .value     (value),
    .ndigits   (ndigits),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef BCD_KEY_ENTRY_BIN_EN
    ,
    .bin       (bin)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] val;
    int          nd;
    int          bn;
  } rec_t;

  rec_t done_exp[$];
  rec_t err_exp[$];

  int checks = 0;
  int errors = 0;
  int cur_edge = 0;

  // Reference model: the number as a list of decimal digits.
  int   digits[$];
  bit   holding = 0;
  int   conv_end = -1;
  bit   pend_valid = 0;
  int   pend_due = 0;
  int   pend_bin = 0;
  int   bin_exp = 0;
  bit   busy_exp = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at edge %0d",
               name, act, act, exp, exp, cur_edge);
    end
  endtask

  function automatic logic [15:0] model_value();
    logic [15:0] v = '0;
    foreach (digits[i]) v = v * 16 + 16'(digits[i]);
    return v;
  endfunction

  function automatic int model_decimal();
    int n = 0;
    foreach (digits[i]) n = n * 10 + digits[i];
    return n;
  endfunction

  function automatic rec_t snap(input int e);
    rec_t r;
    r.cyc = e;
    r.val = model_value();
    r.nd  = digits.size();
    r.bn  = bin_exp;
    return r;
  endfunction

  task automatic model_reset();
    digits.delete();
    holding = 0; conv_end = -1; pend_valid = 0; bin_exp = 0; busy_exp = 0;
  endtask

  task automatic model_step(input int e, input bit c, input bit en, input bit dv,
                            input int d);
    bit push_err = 0;
    if (c) begin
      model_reset();
    end else if (conv_end >= 0 && e <= conv_end) begin
      if (e == conv_end) begin
        bin_exp  = pend_bin;
        conv_end = -1;
      end
    end else if (en) begin
      if (!holding) begin
        holding    = 1;
        pend_valid = 1;
        pend_bin   = model_decimal();
`ifdef BCD_KEY_ENTRY_BIN_EN
        pend_due = e + 5;
        conv_end = e + 4;
`else
        pend_due = e + 1;
`endif
      end
    end else if (dv) begin
      if (d > 9 || (!holding && digits.size() == 4)) push_err = 1;
      else if (holding) begin
        digits.delete();
        digits.push_back(d);
        holding = 0;
      end else digits.push_back(d);
    end
    busy_exp = (conv_end >= 0 && e < conv_end);
    if (push_err) err_exp.push_back(snap(e));
    if (pend_valid && e == pend_due) begin
      done_exp.push_back(snap(e));
      pend_valid = 0;
    end
  endtask

  // Inputs change 1ns after the edge; the model steps on the edge that samples them.
  task automatic drive(input bit c, input bit en, input bit dv, input int d);
    clear = c; enter = en; digit_vld = dv; digit = 4'(d);
    @(posedge clk);
    cur_edge++;
    model_step(cur_edge, c, en, dv, d);
    #1;
    clear = 0; enter = 0; digit_vld = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  task automatic key(input int d);
    drive(0, 0, 1, d);
  endtask

  task automatic check_now(input string tag);
    @(negedge clk);
    chk({tag, "_value"}, int'(value), int'(model_value()));
    chk({tag, "_ndigits"}, int'(ndigits), digits.size());
`ifdef BCD_KEY_ENTRY_BIN_EN
    if (conv_end < 0) chk({tag, "_bin"}, int'(bin), bin_exp);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_value"}, int'(value), 0);
    chk({tag, "_ndigits"}, int'(ndigits), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
`ifdef BCD_KEY_ENTRY_BIN_EN
    chk({tag, "_bin"}, int'(bin), 0);
`endif
  endtask

  // Monitor: pops expected pulses when the DUT shows them, flags late or stray ones.
  always @(negedge clk) begin
    if (CLR_N) begin
      rec_t r;
      chk("busy", int'(busy), int'(busy_exp));
      while (done_exp.size() > 0 && done_exp[0].cyc < cur_edge) begin
        r = done_exp.pop_front();
        chk("done_missing_at_edge", 0, r.cyc);
      end
      while (err_exp.size() > 0 && err_exp[0].cyc < cur_edge) begin
        r = err_exp.pop_front();
        chk("err_missing_at_edge", 0, r.cyc);
      end
      if (done) begin
        if (done_exp.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          r = done_exp.pop_front();
          chk("done_cycle", cur_edge, r.cyc);
          chk("done_value", int'(value), int'(r.val));
          chk("done_ndigits", int'(ndigits), r.nd);
`ifdef BCD_KEY_ENTRY_BIN_EN
          chk("done_bin", int'(bin), r.bn);
`endif
        end
      end
      if (err) begin
        if (err_exp.size() == 0) chk("err_unexpected", 1, 0);
        else begin
          r = err_exp.pop_front();
          chk("err_cycle", cur_edge, r.cyc);
          chk("err_value", int'(value), int'(r.val));
          chk("err_ndigits", int'(ndigits), r.nd);
        end
      end
    end
  end

  initial begin
    #3;
    check_all_zero("reset");
    #9;
    CLR_N = 1'b1;

    // 1,2,3,4 then enter
    key(1); key(2); key(3); key(4);
    check_now("four_digits");
    drive(0, 1, 0, 0);
    idle(7);
    chk("value_1234", int'(value), 16'h1234);

    // overflow digit and non-BCD digit
    drive(1, 0, 0, 0);
    key(9); key(9); key(9); key(9); key(5);
    check_now("overflow");
    drive(0, 1, 0, 0);
    idle(7);
    drive(1, 0, 0, 0);
    key(4'hA);
    idle(2);
    check_now("non_bcd");

    // enter and digit in the same cycle, then a fresh number from HOLD
    key(7); key(3);
    drive(0, 1, 1, 5);
    idle(7);
    chk("value_0073", int'(value), 16'h0073);
    key(8);
    check_now("restart");
    chk("value_0008", int'(value), 16'h0008);

    // enter on an empty number
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    idle(7);
    check_now("empty");

    // clear two edges after enter
    key(2); key(5);
    drive(0, 1, 0, 0);
    idle(1);
    drive(1, 0, 0, 0);
    idle(6);
    check_now("abort");

    // asynchronous reset in the middle of a conversion
    key(6); key(1);
    drive(0, 1, 0, 0);
    idle(2);
    #2;
    CLR_N = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_reset");
    #3;
    CLR_N = 1'b1;
    key(3);
    check_now("after_reset");

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit c  = ($urandom_range(0, 99) < 3);
      bit en = ($urandom_range(0, 99) < 10);
      bit dv = ($urandom_range(0, 99) < 55);
      int d  = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      drive(c, en, dv, d);
      if (i % 25 == 24) check_now("random");
    end

    idle(8);
    chk("done_queue_empty", done_exp.size(), 0);
    chk("err_queue_empty", err_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
